// File: rtl/mac_seq_int_if.sv
// mac_seq_int_if
// Operand / result handshake bundle for the sequential dot-product engine.
//   in_valid  / in_ready  : operand vectors offered / accepted (IDLE only)
//   weights, x            : DIM elements of BITW bits, element 0 in the MSBs
//   out_valid / out_ready : result offered / consumed
//   out                   : ACCW-bit dot product
// Modports: master drives operands and out_ready, slave is the engine.
interface mac_seq_int_if #(
  parameter int DIM  = 4,
  parameter int BITW = 8,
  parameter int ACCW = 2*BITW + $clog2(DIM)
);
  logic                           in_valid;
  logic                           in_ready;
  logic [0:DIM-1][BITW-1:0]       weights;
  logic [0:DIM-1][BITW-1:0]       x;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACCW-1:0]                out;

  modport master (
    output in_valid, weights, x, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, weights, x, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/mac_seq_int.sv
// mac_seq_int
// Sequential integer multiply-accumulate: dot product of two DIM-element
// vectors, LANES element pairs per cycle, full-precision ACCW accumulator.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : mac_seq_int_if.slave (operand and result handshakes)
//   busy  : high while computing or holding an unconsumed result
//
// Build option: define MAC_SIGNED_EN to treat operands as two's complement
// (sign-extended); otherwise operands are unsigned (zero-extended).
// Handshake and latency are identical in both builds.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | accumulating LANES products per cycle
// DONE  | result presented, waiting for out_ready
module mac_seq_int #(
  parameter int DIM   = 4,
  parameter int BITW  = 8,
  parameter int LANES = 2,
  parameter int ACCW  = 2*BITW + $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_int_if.slave  bus,
  output logic          busy
);

  localparam int STEPS = DIM / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [0:DIM-1][BITW-1:0] w_q;
  logic [0:DIM-1][BITW-1:0] x_q;
  logic [ACCW-1:0]          acc;
  logic [ACCW-1:0]          lane_sum;
  logic [ACCW-1:0]          out_q;
  logic [SW-1:0]            step;
  logic                     last_step;
  logic                     accept;

  // Operands are widened to ACCW before multiplying, so the truncated
  // ACCW-bit product is exact in both signed and unsigned interpretation.
  function automatic logic [ACCW-1:0] ext(input logic [BITW-1:0] v);
`ifdef MAC_SIGNED_EN
    return {{(ACCW-BITW){v[BITW-1]}}, v};
`else
    return {{(ACCW-BITW){1'b0}}, v};
`endif
  endfunction

  assign last_step = (step == SW'(STEPS-1));
  assign accept    = (state == S_IDLE) && bus.in_valid;

  // Operand registers shift LANES elements toward index 0 each BUSY cycle,
  // so the lanes always read fixed positions 0..LANES-1.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + ext(w_q[l]) * ext(x_q[l]);
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.in_valid) state_nxt = S_BUSY;
      S_BUSY: if (last_step)    state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // output decode; in_ready is held low for the whole time rst is asserted
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      S_IDLE: bus.in_ready  = !rst;
      S_BUSY: busy          = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= '0;
      x_q   <= '0;
      acc   <= '0;
      step  <= '0;
      out_q <= '0;
    end else if (accept) begin
      w_q  <= bus.weights;
      x_q  <= bus.x;
      acc  <= '0;
      step <= '0;
    end else if (state == S_BUSY) begin
      w_q  <= w_q << (LANES*BITW);
      x_q  <= x_q << (LANES*BITW);
      acc  <= acc + lane_sum;
      step <= step + SW'(1);
      if (last_step) begin
        out_q <= acc + lane_sum;
      end
    end
  end

  assign bus.out = out_q;

endmodule
